jtag_ir_decode: RTL

// - JTAG instruction register plus data-register select decoder: the TDI/control-side counterpart of the G1 TDO output mux.
// - Shifts the instruction in from TDI and holds the active 4-bit CODE that drives the TDO mux select.
// - Decodes CODE into one-hot capture, shift and update strobes for each data register (BYPASS, BSR, DEVICE_ID, BIST_CONF, BIST_STATUS, BIST_USER_TEST).
// - Sits between the TAP state machine and the data registers.

---
 rtl/jtag_pkg.sv | 33 +++
 rtl/jtag_ir_decode_if.sv | 50 +++++
 rtl/jtag_ir_shift.sv | 49 ++++
 rtl/jtag_ir_decode.sv | 105 ++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Purpose : Shared definitions for the JTAG instruction register / data-register
//           select decoder: instruction codes, DR_SEL bit positions, the number
//           of data registers and the code legalization function.
// Ports   : none (package).
// Config  : none here; JTAG_IR_PARITY_EN is handled by the users of this package.
// -----------------------------------------------------------------------------
package jtag_pkg;

  localparam int NUM_DR = 6;

  localparam logic [3:0] BYPASS         = 4'h0;
  localparam logic [3:0] BSR            = 4'h1;
  localparam logic [3:0] DEVICE_ID      = 4'h2;
  localparam logic [3:0] BIST_CONF      = 4'h3;
  localparam logic [3:0] BIST_STATUS    = 4'h4;
  localparam logic [3:0] BIST_USER_TEST = 4'h5;

  localparam int SEL_BYPASS         = 0;
  localparam int SEL_BSR            = 1;
  localparam int SEL_DEVICE_ID      = 2;
  localparam int SEL_BIST_CONF      = 3;
  localparam int SEL_BIST_STATUS    = 4;
  localparam int SEL_BIST_USER_TEST = 5;

  // Unimplemented opcodes fall back to BYPASS so an unknown instruction
  // always leaves a 1-bit path between TDI and TDO.
  function automatic logic [3:0] legalize(input logic [3:0] code);
    legalize = (code > BIST_USER_TEST) ? BYPASS : code;
  endfunction

endpackage

// File: rtl/jtag_ir_decode_if.sv
// -----------------------------------------------------------------------------
// jtag_ir_decode_if
// Purpose : Bundles the TAP strobes, serial data and decoder outputs that run
//           between the TAP controller, the IR decoder and the data registers.
// Members : TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR, CAPTURE_DR, SHIFT_DR,
//           UPDATE_DR, TDI           (TAP side -> decoder)
//           IR_TDO, CODE[3:0], DR_SEL/DR_CAPTURE/DR_SHIFT/DR_UPDATE[5:0],
//           IR_ERR (only with JTAG_IR_PARITY_EN)   (decoder -> TAP/DRs)
// Modports: master = TAP side, slave = decoder.
// Config  : JTAG_IR_PARITY_EN adds the IR_ERR member.
// -----------------------------------------------------------------------------
interface jtag_ir_decode_if;

  logic                       TLR;
  logic                       CAPTURE_IR;
  logic                       SHIFT_IR;
  logic                       UPDATE_IR;
  logic                       CAPTURE_DR;
  logic                       SHIFT_DR;
  logic                       UPDATE_DR;
  logic                       TDI;
  logic                       IR_TDO;
  logic [3:0]                 CODE;
  logic [jtag_pkg::NUM_DR-1:0] DR_SEL;
  logic [jtag_pkg::NUM_DR-1:0] DR_CAPTURE;
  logic [jtag_pkg::NUM_DR-1:0] DR_SHIFT;
  logic [jtag_pkg::NUM_DR-1:0] DR_UPDATE;
`ifdef JTAG_IR_PARITY_EN
  logic                       IR_ERR;
`endif

  modport master (
    output TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR,
    output CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDI,
`ifdef JTAG_IR_PARITY_EN
    input  IR_ERR,
`endif
    input  IR_TDO, CODE, DR_SEL, DR_CAPTURE, DR_SHIFT, DR_UPDATE
  );

  modport slave (
    input  TLR, CAPTURE_IR, SHIFT_IR, UPDATE_IR,
    input  CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDI,
`ifdef JTAG_IR_PARITY_EN
    output IR_ERR,
`endif
    output IR_TDO, CODE, DR_SEL, DR_CAPTURE, DR_SHIFT, DR_UPDATE
  );

endinterface

// File: rtl/jtag_ir_shift.sv
// -----------------------------------------------------------------------------
// jtag_ir_shift
// Purpose : Instruction shift stage (IR_SR): parallel capture, LSB-first serial
//           shift and the IR serial output.
// Ports   : clk, rst        clock (posedge) and synchronous active-high reset
//           tlr             Test-Logic-Reset soft reset
//           capture_ir, shift_ir, update_ir   TAP IR strobes
//           tdi             serial data in
//           ir_sr[SR_W-1:0] shift stage contents (to the update stage)
//           ir_tdo          serial out, IR_SR[0]
// Config  : SR_W is IR_W+1 when the top is built with JTAG_IR_PARITY_EN,
//           the extra MSB holding the parity bit.
// -----------------------------------------------------------------------------
module jtag_ir_shift #(
  parameter int              IR_W    = 4,
  parameter int              SR_W    = 4,
  parameter logic [IR_W-1:0] CAP_VAL = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tlr,
  input  logic            capture_ir,
  input  logic            shift_ir,
  input  logic            update_ir,
  input  logic            tdi,
  output logic [SR_W-1:0] ir_sr,
  output logic            ir_tdo
);

  // The parity bit (if any) is captured as 0; the shifter fills it last.
  localparam logic [SR_W-1:0] CAP_EXT = SR_W'(CAP_VAL);

  // Update-IR holds the shift stage so the update stage samples a stable
  // value; resets outrank every strobe and discard any partial scan.
  always_ff @(posedge clk) begin
    if (rst || tlr) begin
      ir_sr <= CAP_EXT;
    end else if (update_ir) begin
      ir_sr <= ir_sr;
    end else if (capture_ir) begin
      ir_sr <= CAP_EXT;
    end else if (shift_ir) begin
      ir_sr <= {tdi, ir_sr[SR_W-1:1]};
    end
  end

  assign ir_tdo = ir_sr[0];

endmodule

// File: rtl/jtag_ir_decode.sv
// -----------------------------------------------------------------------------
// jtag_ir_decode
// Purpose : JTAG instruction register plus data-register select decoder.
//           Holds the active instruction CODE (TDO mux select) and turns it
//           into one-hot select and capture/shift/update strobes for the six
//           data registers.
// Ports   : TCK   JTAG clock, all flops on posedge
//           RST   synchronous active-high reset
//           jtag  jtag_ir_decode_if.slave: TAP strobes and TDI in; IR_TDO,
//                 CODE, DR_SEL, DR_CAPTURE/SHIFT/UPDATE (and IR_ERR) out
// Config  : `define JTAG_IR_PARITY_EN adds an odd-parity bit to the IR and the
//           sticky IR_ERR flag; a bad-parity update selects BYPASS.
// -----------------------------------------------------------------------------
module jtag_ir_decode
  import jtag_pkg::*;
#(
  parameter int              IR_W    = 4,
  parameter logic [IR_W-1:0] CAP_VAL = 4'b0001
) (
  input  logic              TCK,
  input  logic              RST,
  jtag_ir_decode_if.slave   jtag
);

`ifdef JTAG_IR_PARITY_EN
  localparam int SR_W = IR_W + 1;
`else
  localparam int SR_W = IR_W;
`endif

  logic [SR_W-1:0]   ir_sr;
  logic [3:0]        code_q;
  logic [NUM_DR-1:0] dr_sel;
  logic              parity_ok;

  jtag_ir_shift #(
    .IR_W    (IR_W),
    .SR_W    (SR_W),
    .CAP_VAL (CAP_VAL)
  ) u_shift (
    .clk        (TCK),
    .rst        (RST),
    .tlr        (jtag.TLR),
    .capture_ir (jtag.CAPTURE_IR),
    .shift_ir   (jtag.SHIFT_IR),
    .update_ir  (jtag.UPDATE_IR),
    .tdi        (jtag.TDI),
    .ir_sr      (ir_sr),
    .ir_tdo     (jtag.IR_TDO)
  );

`ifdef JTAG_IR_PARITY_EN
  // Odd parity over the full shift stage is the only acceptable instruction.
  assign parity_ok = ^ir_sr;

  logic ir_err_q;

  // Sticky error: only RST clears it, TLR leaves it for software to read.
  always_ff @(posedge TCK) begin
    if (RST) begin
      ir_err_q <= 1'b0;
    end else if (!jtag.TLR && jtag.UPDATE_IR && !parity_ok) begin
      ir_err_q <= 1'b1;
    end
  end

  assign jtag.IR_ERR = ir_err_q;
`else
  assign parity_ok = 1'b1;
`endif

  // Update stage: CODE moves only on RST, TLR or UPDATE_IR, so it is stable
  // across any DR scan.
  always_ff @(posedge TCK) begin
    if (RST || jtag.TLR) begin
      code_q <= DEVICE_ID;
    end else if (jtag.UPDATE_IR) begin
      code_q <= parity_ok ? legalize(ir_sr[3:0]) : BYPASS;
    end
  end

  // code_q only ever holds legal codes; the default keeps the select one-hot
  // even if that invariant were ever broken.
  always_comb begin
    dr_sel = '0;
    case (code_q)
      BYPASS:         dr_sel[SEL_BYPASS]         = 1'b1;
      BSR:            dr_sel[SEL_BSR]            = 1'b1;
      DEVICE_ID:      dr_sel[SEL_DEVICE_ID]      = 1'b1;
      BIST_CONF:      dr_sel[SEL_BIST_CONF]      = 1'b1;
      BIST_STATUS:    dr_sel[SEL_BIST_STATUS]    = 1'b1;
      BIST_USER_TEST: dr_sel[SEL_BIST_USER_TEST] = 1'b1;
      default:        dr_sel[SEL_BYPASS]         = 1'b1;
    endcase
  end

  assign jtag.CODE   = code_q;
  assign jtag.DR_SEL = dr_sel;

  // Strobes are forced low during reset so no register sees a stray edge.
  assign jtag.DR_CAPTURE = RST ? '0 : (dr_sel & {NUM_DR{jtag.CAPTURE_DR}});
  assign jtag.DR_SHIFT   = RST ? '0 : (dr_sel & {NUM_DR{jtag.SHIFT_DR}});
  assign jtag.DR_UPDATE  = RST ? '0 : (dr_sel & {NUM_DR{jtag.UPDATE_DR}});

endmodule
